// File: rtl/hazard_ctrl.sv
// Purpose : operand-forwarding selects and stall/flush control for a 5-stage in-order pipeline.
// Latency : all outputs combinational from FSM state, MEM/WB shadows and current inputs (0 cycles).
// Backpress: i_pipe_hold freezes FSM and shadows and forces IF/ID stall; no flushes while held.
//
// Ports
//   i_clk, i_rst               clock (rising edge), asynchronous active-high reset
//   i_id_src_0/1, i_id_use_0/1 decode-stage source registers and "really read" flags
//   i_ie_src_0/1               execute-stage source registers (forwarding lookup keys)
//   i_ie_dst/_rf_we/_is_load   execute-stage destination, becomes the MEM/WB shadows
//   i_nxt_pc_src               taken branch/jump resolved in execute
//   i_pipe_hold                external freeze (memory not ready)
//   o_forward_0/1              00 register file, 01 MEM ALU result, 10 WB result
//   o_if_stall, o_id_stall     hold PC / hold IF-ID register
//   o_id_flush, o_ie_flush     bubble into IF-ID / ID-IE register
//   o_stall_cnt, o_flush_cnt   only with HAZARD_PERF_EN: load-use and branch-flush event counters
//
// Build option: define HAZARD_PERF_EN to add the two 32-bit performance counters.

module hazard_ctrl #(
    parameter int RF_ADD_SIZE = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [RF_ADD_SIZE-1:0] i_id_src_0,
    input  logic [RF_ADD_SIZE-1:0] i_id_src_1,
    input  logic                   i_id_use_0,
    input  logic                   i_id_use_1,
    input  logic [RF_ADD_SIZE-1:0] i_ie_src_0,
    input  logic [RF_ADD_SIZE-1:0] i_ie_src_1,
    input  logic [RF_ADD_SIZE-1:0] i_ie_dst,
    input  logic                   i_ie_rf_we,
    input  logic                   i_ie_is_load,
    input  logic                   i_nxt_pc_src,
    input  logic                   i_pipe_hold,
    output logic [1:0]             o_forward_0,
    output logic [1:0]             o_forward_1,
    output logic                   o_if_stall,
    output logic                   o_id_stall,
    output logic                   o_id_flush,
    output logic                   o_ie_flush
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]            o_stall_cnt,
    output logic [31:0]            o_flush_cnt
`endif
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Destination info of the instruction one stage past execute.
    typedef struct packed {
        logic [RF_ADD_SIZE-1:0] dst;
        logic                   we;
        logic                   ld;
    } mem_stage_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        BR_FLUSH = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    mem_stage_t             mem_q;
    logic [RF_ADD_SIZE-1:0] wb_dst_q;
    logic                   wb_we_q;
    logic                   load_use;

    // ------------------------------------------------------------------
    // MEM / WB shadows: follow the pipeline unless it is frozen.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mem_q    <= '0;
            wb_dst_q <= '0;
            wb_we_q  <= 1'b0;
        end else if (!i_pipe_hold) begin
            mem_q.dst <= i_ie_dst;
            mem_q.we  <= i_ie_rf_we;
            mem_q.ld  <= i_ie_is_load;
            wb_dst_q  <= mem_q.dst;
            wb_we_q   <= mem_q.we;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding. A load in MEM has no data yet, so it never forwards
    // from MEM; the load-use stall guarantees it is in WB by the time
    // the consumer reaches execute. Register 0 is hardwired and never
    // forwarded.
    // ------------------------------------------------------------------
    function automatic logic [1:0] fwd_sel(input logic [RF_ADD_SIZE-1:0] src,
                                           input mem_stage_t             mem,
                                           input logic [RF_ADD_SIZE-1:0] wb_dst,
                                           input logic                   wb_we);
        logic [1:0] sel;
        sel = FWD_RF;
        if (mem.we && (mem.dst != '0) && (mem.dst == src) && !mem.ld) begin
            sel = FWD_MEM;
        end else if (wb_we && (wb_dst != '0) && (wb_dst == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        o_forward_0 = FWD_RF;
        o_forward_1 = FWD_RF;
        if (!i_rst) begin
            o_forward_0 = fwd_sel(i_ie_src_0, mem_q, wb_dst_q, wb_we_q);
            o_forward_1 = fwd_sel(i_ie_src_1, mem_q, wb_dst_q, wb_we_q);
        end
    end

    // ------------------------------------------------------------------
    // Load-use: the load in execute writes a register the decode-stage
    // instruction actually reads.
    // ------------------------------------------------------------------
    always_comb begin
        load_use = 1'b0;
        if (i_ie_is_load && i_ie_rf_we && (i_ie_dst != '0)) begin
            load_use = (i_id_use_0 && (i_id_src_0 == i_ie_dst)) ||
                       (i_id_use_1 && (i_id_src_1 == i_ie_dst));
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        o_if_stall = 1'b0;
        o_id_stall = 1'b0;
        o_id_flush = 1'b0;
        o_ie_flush = 1'b0;

        if (i_rst) begin
            // Outputs stay quiet for the whole reset pulse.
            state_d = RUN;
        end else if (i_pipe_hold) begin
            // Freeze everything; decisions are re-evaluated once hold drops.
            o_if_stall = 1'b1;
            o_id_stall = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (i_nxt_pc_src) begin
                        o_id_flush = 1'b1;
                        o_ie_flush = 1'b1;
                        state_d    = BR_FLUSH;
                    end else if (load_use) begin
                        o_if_stall = 1'b1;
                        o_id_stall = 1'b1;
                        o_ie_flush = 1'b1;
                        state_d    = LU_STALL;
                    end
                end
                LU_STALL: begin
                    // IE holds the inserted bubble; the consumer re-decodes
                    // against that bubble, so load-use is not re-checked.
                    // A branch may still resolve here and takes priority.
                    if (i_nxt_pc_src) begin
                        o_id_flush = 1'b1;
                        o_ie_flush = 1'b1;
                        state_d    = BR_FLUSH;
                    end else begin
                        state_d = RUN;
                    end
                end
                BR_FLUSH: begin
                    // IE holds a flushed instruction: its branch/load flags are stale.
                    state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    // ------------------------------------------------------------------
    // Event counters. state_d already equals state_q during hold, so
    // the entry terms cannot fire while frozen.
    // ------------------------------------------------------------------
    logic        lu_enter;
    logic        br_enter;
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    assign lu_enter = (state_d == LU_STALL) && (state_q != LU_STALL);
    assign br_enter = (state_d == BR_FLUSH) && (state_q != BR_FLUSH);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (lu_enter) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (br_enter) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose : self-checking bench for hazard_ctrl: directed scenarios then randomized traffic.
// Latency : outputs compared every cycle against a reference model, 1 time unit after inputs settle.
// Backpress: i_pipe_hold exercised in both directed and random phases.

module tb_hazard_ctrl;

    localparam int W = 5;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic [W-1:0] i_id_src_0, i_id_src_1;
    logic         i_id_use_0, i_id_use_1;
    logic [W-1:0] i_ie_src_0, i_ie_src_1;
    logic [W-1:0] i_ie_dst;
    logic         i_ie_rf_we, i_ie_is_load;
    logic         i_nxt_pc_src, i_pipe_hold;
    logic [1:0]   o_forward_0, o_forward_1;
    logic         o_if_stall, o_id_stall, o_id_flush, o_ie_flush;
`ifdef HAZARD_PERF_EN
    logic [31:0]  o_stall_cnt, o_flush_cnt;
`endif

    always #5 i_clk = ~i_clk;

    hazard_ctrl #(.RF_ADD_SIZE(W)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_id_src_0   (i_id_src_0),
        .i_id_src_1   (i_id_src_1),
        .i_id_use_0   (i_id_use_0),
        .i_id_use_1   (i_id_use_1),
        .i_ie_src_0   (i_ie_src_0),
        .i_ie_src_1   (i_ie_src_1),
        .i_ie_dst     (i_ie_dst),
        .i_ie_rf_we   (i_ie_rf_we),
        .i_ie_is_load (i_ie_is_load),
        .i_nxt_pc_src (i_nxt_pc_src),
        .i_pipe_hold  (i_pipe_hold),
        .o_forward_0  (o_forward_0),
        .o_forward_1  (o_forward_1),
        .o_if_stall   (o_if_stall),
        .o_id_stall   (o_id_stall),
        .o_id_flush   (o_id_flush),
        .o_ie_flush   (o_ie_flush)
`ifdef HAZARD_PERF_EN
        ,
        .o_stall_cnt  (o_stall_cnt),
        .o_flush_cnt  (o_flush_cnt)
`endif
    );

    // ------------------------------------------------------------------
    // Reference model: history of retired-from-execute instructions
    // (index 0 = one stage past execute, 1 = two stages past) plus
    // flags telling whether execute currently holds a bubble we caused.
    // ------------------------------------------------------------------
    logic [W-1:0] h_dst [2];
    logic         h_we  [2];
    logic         h_ld  [2];
    bit           m_lu_bubble;
    bit           m_br_bubble;
    int unsigned  m_lu_cnt;
    int unsigned  m_br_cnt;

    int vectors     = 0;
    int miscompares = 0;

    task automatic reset_model();
        for (int k = 0; k < 2; k++) begin
            h_dst[k] = '0;
            h_we[k]  = 1'b0;
            h_ld[k]  = 1'b0;
        end
        m_lu_bubble = 0;
        m_br_bubble = 0;
        m_lu_cnt    = 0;
        m_br_cnt    = 0;
    endtask

    function automatic logic [1:0] exp_fwd(input logic [W-1:0] src);
        if (i_rst) return 2'b00;
        if (h_we[0] && h_dst[0] != 0 && h_dst[0] == src && !h_ld[0]) return 2'b01;
        if (h_we[1] && h_dst[1] != 0 && h_dst[1] == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit lu_now();
        if (!(i_ie_is_load && i_ie_rf_we && i_ie_dst != 0)) return 0;
        return (i_id_use_0 && i_id_src_0 == i_ie_dst) || (i_id_use_1 && i_id_src_1 == i_ie_dst);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic e_ifs, e_ids, e_idf, e_ief;
        e_ifs = 1'b0; e_ids = 1'b0; e_idf = 1'b0; e_ief = 1'b0;
        if (!i_rst) begin
            if (i_pipe_hold) begin
                e_ifs = 1'b1; e_ids = 1'b1;
            end else if (m_br_bubble) begin
                e_ifs = 1'b0;
            end else if (i_nxt_pc_src) begin
                e_idf = 1'b1; e_ief = 1'b1;
            end else if (!m_lu_bubble && lu_now()) begin
                e_ifs = 1'b1; e_ids = 1'b1; e_ief = 1'b1;
            end
        end
        chk({tag, ".fwd0"},     32'(o_forward_0), 32'(exp_fwd(i_ie_src_0)));
        chk({tag, ".fwd1"},     32'(o_forward_1), 32'(exp_fwd(i_ie_src_1)));
        chk({tag, ".if_stall"}, 32'(o_if_stall),  32'(e_ifs));
        chk({tag, ".id_stall"}, 32'(o_id_stall),  32'(e_ids));
        chk({tag, ".id_flush"}, 32'(o_id_flush),  32'(e_idf));
        chk({tag, ".ie_flush"}, 32'(o_ie_flush),  32'(e_ief));
`ifdef HAZARD_PERF_EN
        chk({tag, ".stall_cnt"}, o_stall_cnt, i_rst ? 32'd0 : m_lu_cnt);
        chk({tag, ".flush_cnt"}, o_flush_cnt, i_rst ? 32'd0 : m_br_cnt);
`endif
    endtask

    // Apply the outcome of the clock edge that just happened.
    task automatic advance();
        bit br, lu;
        if (i_rst) begin
            reset_model();
        end else if (!i_pipe_hold) begin
            br = !m_br_bubble && i_nxt_pc_src;
            lu = !m_br_bubble && !i_nxt_pc_src && !m_lu_bubble && lu_now();
            h_dst[1] = h_dst[0]; h_we[1] = h_we[0]; h_ld[1] = h_ld[0];
            h_dst[0] = i_ie_dst; h_we[0] = i_ie_rf_we; h_ld[0] = i_ie_is_load;
            m_br_bubble = br;
            m_lu_bubble = lu;
            if (br) m_br_cnt++;
            if (lu) m_lu_cnt++;
        end
    endtask

    // Inputs are set 1 unit after a rising edge; check, then cross the next edge.
    task automatic step(input string tag);
        #1;
        check_all(tag);
        @(posedge i_clk);
        #1;
        advance();
    endtask

    task automatic idle();
        i_id_src_0 = '0; i_id_src_1 = '0; i_id_use_0 = 1'b0; i_id_use_1 = 1'b0;
        i_ie_src_0 = '0; i_ie_src_1 = '0; i_ie_dst = '0;
        i_ie_rf_we = 1'b0; i_ie_is_load = 1'b0;
        i_nxt_pc_src = 1'b0; i_pipe_hold = 1'b0;
    endtask

    initial begin
`ifdef HAZARD_PERF_EN
        int unsigned cnt0;
`endif
        reset_model();
        idle();

        // Reset state, including hold asserted during reset.
        i_rst = 1'b1;
        i_pipe_hold = 1'b1;
        #1;
        chk("rst.if_stall_gated", 32'(o_if_stall), 32'd0);
        step("reset");
        i_pipe_hold = 1'b0;
        step("reset2");
        i_rst = 1'b0;
        step("idle");

        // Forward from MEM, then from WB.
        i_ie_dst = 5'd5; i_ie_rf_we = 1'b1;
        step("fwd.produce");
        idle(); i_ie_src_0 = 5'd5;
        #1; chk("fwd.mem", 32'(o_forward_0), 32'd1);
        step("fwd.mem");
        idle(); i_ie_src_1 = 5'd5;
        #1; chk("fwd.wb", 32'(o_forward_1), 32'd2);
        step("fwd.wb");

        // Load-use: stall one cycle, bubble cycle, then run with WB forward.
        idle(); i_ie_dst = 5'd7; i_ie_rf_we = 1'b1; i_ie_is_load = 1'b1;
        i_id_src_1 = 5'd7; i_id_use_1 = 1'b1;
        #1; chk("lu.stall", 32'({o_if_stall, o_id_stall, o_ie_flush}), 32'b111);
        step("lu.detect");
        idle(); i_id_src_1 = 5'd7; i_id_use_1 = 1'b1;
        i_ie_dst = 5'd7; i_ie_rf_we = 1'b1; i_ie_is_load = 1'b1;
        #1; chk("lu.bubble", 32'({o_if_stall, o_id_stall, o_ie_flush}), 32'b000);
        step("lu.bubble");
        idle(); i_ie_src_1 = 5'd7;
        step("lu.consumer");

        // Branch coincident with load-use; branch held high next cycle.
        idle(); i_ie_dst = 5'd9; i_ie_rf_we = 1'b1; i_ie_is_load = 1'b1;
        i_id_src_0 = 5'd9; i_id_use_0 = 1'b1; i_nxt_pc_src = 1'b1;
        #1; chk("br.flush", 32'({o_if_stall, o_id_stall, o_id_flush, o_ie_flush}), 32'b0011);
        step("br.win");
        #1; chk("br.held", 32'({o_id_flush, o_ie_flush}), 32'b00);
        step("br.held");
        idle();
        step("br.after");

        // x0 destination: neither stall nor forwarding.
        i_ie_dst = 5'd0; i_ie_rf_we = 1'b1; i_ie_is_load = 1'b1;
        i_id_src_0 = 5'd0; i_id_use_0 = 1'b1;
        step("x0.nostall");
        idle(); i_ie_src_0 = 5'd0;
        step("x0.nofwd");

        // Hold for 3 cycles during a load-use, MEM shadow must stay frozen.
        idle(); i_ie_dst = 5'd3; i_ie_rf_we = 1'b1;
        step("hold.pre");
        idle(); i_ie_dst = 5'd11; i_ie_rf_we = 1'b1; i_ie_is_load = 1'b1;
        i_id_src_0 = 5'd11; i_id_use_0 = 1'b1; i_ie_src_0 = 5'd3; i_pipe_hold = 1'b1;
`ifdef HAZARD_PERF_EN
        cnt0 = o_stall_cnt;
`endif
        for (int c = 0; c < 3; c++) begin
            #1; chk("hold.frozen_fwd", 32'(o_forward_0), 32'd1);
            step("hold");
        end
        i_pipe_hold = 1'b0;
        step("hold.release");
        step("hold.bubble");
`ifdef HAZARD_PERF_EN
        chk("hold.stall_cnt_delta", o_stall_cnt - cnt0, 32'd1);
`endif
        idle();
        step("hold.after");

        // Reset while in BR_FLUSH.
        i_nxt_pc_src = 1'b1;
        step("rstbr.enter");
        i_rst = 1'b1; i_pipe_hold = 1'b1;
        #1; chk("rstbr.async", 32'({o_if_stall, o_id_stall, o_id_flush, o_ie_flush}), 32'b0000);
        step("rstbr.inrst");
        idle(); i_rst = 1'b0;
        i_ie_dst = 5'd4; i_ie_rf_we = 1'b1; i_ie_is_load = 1'b1;
        i_id_src_1 = 5'd4; i_id_use_1 = 1'b1;
        #1; chk("rstbr.run", 32'(o_ie_flush), 32'd1);
        step("rstbr.run");
        idle();
        step("rstbr.after");

        // Randomized traffic on a small register range for frequent hits.
        for (int n = 0; n < 3000; n++) begin
            i_rst        = ($urandom_range(0, 99) == 0);
            i_pipe_hold  = ($urandom_range(0, 4) == 0);
            i_nxt_pc_src = ($urandom_range(0, 5) == 0);
            i_ie_dst     = W'($urandom_range(0, 3));
            i_ie_rf_we   = ($urandom_range(0, 3) != 0);
            i_ie_is_load = ($urandom_range(0, 2) == 0);
            i_ie_src_0   = W'($urandom_range(0, 3));
            i_ie_src_1   = W'($urandom_range(0, 3));
            i_id_src_0   = W'($urandom_range(0, 3));
            i_id_src_1   = W'($urandom_range(0, 3));
            i_id_use_0   = ($urandom_range(0, 1) == 1);
            i_id_use_1   = ($urandom_range(0, 1) == 1);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
